// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: initiator-side port controller for a 2R/1W register file.
// Latency: operands one cycle after a granted dec_valid; a write commits at the
// earliest one edge after it is accepted. Backpressure: wb_ready drops when the
// FIFO is full; dec_ready is a same-cycle grant held off by hazards, a stalled
// output register or a write winning the port.
// Ports: clk/reset; dec_* operand request; op_* captured operand output;
//        wb_* writeback input; rf_* register file read ports and write port.
module regfile_port_ctrl #(
  parameter int WB_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_rs1_val,
  output logic [31:0] op_rs2_val,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] rf_rs1_addr,
  output logic [31:0] rf_rs2_addr,
  output logic        rf_read_rs1,
  output logic        rf_read_rs2,
  input  logic [31:0] rf_rs1,
  input  logic [31:0] rf_rs2,
  output logic [31:0] rf_rd,
  output logic [31:0] rf_rd_data,
  output logic        rf_rd_write
);

  localparam int AW = $clog2(WB_DEPTH);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(WB_DEPTH);
  localparam logic [SW-1:0] STARVE_L = SW'(STARVE_MAX);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  logic [4:0]          fifo_rd   [WB_DEPTH];
  logic [31:0]         fifo_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] fifo_vld;
  logic [AW:0]         wptr, rptr, count;
  logic [AW-1:0]       widx, head;
  logic                empty, full;
  logic                wb_acc, enq;
  logic                m1, m2, hz, rd_req;
  logic                wr_grant, rd_grant;
  logic [SW-1:0]       starve;
  state_t              state, state_nxt;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == FULL_CNT);
  assign widx  = wptr[AW-1:0];
  assign head  = rptr[AW-1:0];

  assign wb_ready = ~full;
  assign wb_acc   = wb_valid & wb_ready;
  // x0 writes complete the handshake but never occupy an entry.
  assign enq      = wb_acc & (wb_rd != 5'd0);

  // Match each source against every buffered write; x0 is never buffered so
  // only the explicit rs != 0 check is needed for the same-cycle write.
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (fifo_vld[i] && fifo_rd[i] == dec_rs1) m1 = 1'b1;
      if (fifo_vld[i] && fifo_rd[i] == dec_rs2) m2 = 1'b1;
    end
  end

  assign hz = (dec_use_rs1 && dec_rs1 != 5'd0 && (m1 || (enq && wb_rd == dec_rs1))) ||
              (dec_use_rs2 && dec_rs2 != 5'd0 && (m2 || (enq && wb_rd == dec_rs2)));

  assign rd_req   = dec_valid & ~hz & (~op_valid | op_ready);
  // A pending write wins when nobody reads, when the FIFO is full, or when
  // reads have starved it for STARVE_MAX grants in a row.
  assign wr_grant = ~empty & (~rd_req | full | (starve == STARVE_L));
  assign rd_grant = rd_req & ~wr_grant;

  assign dec_ready   = rd_grant;
  assign rf_read_rs1 = rd_grant & dec_use_rs1;
  assign rf_read_rs2 = rd_grant & dec_use_rs2;
  assign rf_rd_write = wr_grant;
  assign rf_rs1_addr = {27'b0, dec_rs1};
  assign rf_rs2_addr = {27'b0, dec_rs2};
  assign rf_rd       = empty ? 32'd0 : {27'b0, fifo_rd[head]};
  assign rf_rd_data  = empty ? 32'd0 : fifo_data[head];

  // FIFO payload storage carries no reset; fifo_vld and pointers qualify it.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[widx]   <= wb_rd;
      fifo_data[widx] <= wb_data;
    end
  end

  // Enqueue and pop never target the same slot: enqueue needs not-full, pop
  // needs not-empty, so in between the tail and head indices differ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_vld <= '0;
    end else begin
      if (enq) begin
        fifo_vld[widx] <= 1'b1;
        wptr           <= wptr + 1'b1;
      end
      if (wr_grant) begin
        fifo_vld[head] <= 1'b0;
        rptr           <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (wr_grant || empty) begin
      starve <= '0;
    end else if (rd_grant && starve != STARVE_L) begin
      starve <= starve + 1'b1;
    end
  end

  // Output register state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (rd_grant) state_nxt = S_HOLD;
      S_HOLD:  if (op_ready && !rd_grant) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  assign op_valid = (state == S_HOLD);

  // Disabled read ports return 0, so an unused operand captures 0 here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_rs1_val <= '0;
      op_rs2_val <= '0;
    end else if (rd_grant) begin
      op_rs1_val <= rf_rs1;
      op_rs2_val <= rf_rs2;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural register file model.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid = 1'b0, dec_ready;
  logic [4:0]  dec_rs1 = '0, dec_rs2 = '0;
  logic        dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
  logic        op_valid, op_ready = 1'b1;
  logic [31:0] op_rs1_val, op_rs2_val;
  logic        wb_valid = 1'b0, wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] rf_rs1_addr, rf_rs2_addr, rf_rs1, rf_rs2, rf_rd, rf_rd_data;
  logic        rf_read_rs1, rf_read_rs2, rf_rd_write;

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] mem [32] = '{default: 32'd0};

  always #5 clk = ~clk;

  regfile_port_ctrl #(.WB_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_val(op_rs1_val), .op_rs2_val(op_rs2_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_read_rs1(rf_read_rs1), .rf_read_rs2(rf_read_rs2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd(rf_rd), .rf_rd_data(rf_rd_data), .rf_rd_write(rf_rd_write)
  );

  // Register file: reads are 0 when disabled or while the write strobe is high.
  assign rf_rs1 = (rf_read_rs1 && !rf_rd_write) ? mem[rf_rs1_addr[4:0]] : 32'd0;
  assign rf_rs2 = (rf_read_rs2 && !rf_rd_write) ? mem[rf_rs2_addr[4:0]] : 32'd0;
  always @(posedge clk)
    if (rf_rd_write && rf_rd[4:0] != 5'd0) mem[rf_rd[4:0]] <= rf_rd_data;

  // A read and a write must never share a cycle.
  always @(negedge clk) begin
    n_asrt++;
    assert (!(rf_rd_write && (rf_read_rs1 || rf_read_rs2))) else begin
      n_fail++;
      $error("FAIL rd_wr_overlap observed=%b%b%b required=no overlap",
             rf_rd_write, rf_read_rs1, rf_read_rs2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; wb_valid = 1'b0;
  endtask

  logic [4:0] exp_dr, exp_wr, exp_ww;

  initial begin
    // Reset state
    #2;
    chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
    chk("rst_op_rs1", op_rs1_val, 32'd0);
    chk("rst_wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("rst_rd_write", {31'b0, rf_rd_write}, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // 1: single writeback, no reads
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; #1;
    chk("t1_wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("t1_no_write_yet", {31'b0, rf_rd_write}, 32'd0);
    tick(); idle(); #1;
    chk("t1_write", {31'b0, rf_rd_write}, 32'd1);
    chk("t1_rd", rf_rd, 32'd5);
    chk("t1_data", rf_rd_data, 32'hDEADBEEF);
    tick();
    chk("t1_once", {31'b0, rf_rd_write}, 32'd0);
    chk("t1_empty_rd", rf_rd, 32'd0);
    chk("t1_mem", mem[5], 32'hDEADBEEF);

    // 2: write to x0 is accepted and dropped
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; #1;
    chk("t2_wb_ready", {31'b0, wb_ready}, 32'd1);
    tick(); idle(); #1;
    chk("t2_no_write", {31'b0, rf_rd_write}, 32'd0);
    chk("t2_empty_data", rf_rd_data, 32'd0);
    tick();
    chk("t2_no_write2", {31'b0, rf_rd_write}, 32'd0);

    // 3: RAW hazard against a buffered write to x7
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h07070707;
    tick(); idle();
    dec_valid = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd0; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b0;
    #1;
    chk("t3_hz_blocked", {31'b0, dec_ready}, 32'd0);
    chk("t3_hz_write", {31'b0, rf_rd_write}, 32'd1);
    tick();
    chk("t3_read_grant", {31'b0, dec_ready}, 32'd1);
    chk("t3_rs1_addr", rf_rs1_addr, 32'd7);
    tick(); idle(); #1;
    chk("t3_op_valid", {31'b0, op_valid}, 32'd1);
    chk("t3_op_rs1", op_rs1_val, 32'h07070707);
    chk("t3_op_rs2", op_rs2_val, 32'd0);
    // same-cycle hazard: wb x3 accepted while dec reads x3
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    dec_valid = 1'b1; dec_rs1 = 5'd3; #1;
    chk("t3_same_cycle_hz", {31'b0, dec_ready}, 32'd0);
    tick(); idle(); tick();

    // preload x1=0x11, x2=2
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h11; tick();
    wb_rd = 5'd2; wb_data = 32'h2; tick();
    idle(); tick(); tick();
    chk("pre_mem2", mem[2], 32'h2);

    // 4: reads starve writes for at most 3 grants; full forces a write
    exp_dr = 5'b01111; exp_wr = 5'b01111; exp_ww = 5'b10000;
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; op_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dec_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h900 + i; #1;
      chk($sformatf("t4_dec_ready_%0d", i), {31'b0, dec_ready}, {31'b0, exp_dr[i]});
      chk($sformatf("t4_wb_ready_%0d", i), {31'b0, wb_ready}, {31'b0, exp_wr[i]});
      chk($sformatf("t4_rd_write_%0d", i), {31'b0, rf_rd_write}, {31'b0, exp_ww[i]});
      tick();
    end
    idle(); #1;
    chk("t4_op_rs1", op_rs1_val, 32'h11);
    chk("t4_op_rs2", op_rs2_val, 32'h2);
    chk("t4_op_valid_drop", {31'b0, op_valid}, 32'd0);
    chk("t4_fifo_order", rf_rd_data, 32'h901);
    tick(); tick(); tick();
    chk("t4_drained", {31'b0, rf_rd_write}, 32'd0);
    chk("t4_mem9", mem[9], 32'h903);

    // 5: unused rs2 reads 0; held output with op_ready low
    op_ready = 1'b0; dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b0; #1;
    chk("t5_dec_ready", {31'b0, dec_ready}, 32'd1);
    chk("t5_read_rs2", {31'b0, rf_read_rs2}, 32'd0);
    tick();
    chk("t5_op_valid", {31'b0, op_valid}, 32'd1);
    chk("t5_op_rs1", op_rs1_val, 32'h11);
    chk("t5_op_rs2", op_rs2_val, 32'd0);
    chk("t5_stall_ready", {31'b0, dec_ready}, 32'd0);
    tick();
    chk("t5_hold_rs1", op_rs1_val, 32'h11);
    chk("t5_hold_valid", {31'b0, op_valid}, 32'd1);
    idle(); op_ready = 1'b1; tick();
    chk("t5_release", {31'b0, op_valid}, 32'd0);

    // 6: async reset mid-operation with 3 buffered writes
    dec_use_rs2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA00 + i;
      tick();
    end
    chk("t6_pre_op_valid", {31'b0, op_valid}, 32'd1);
    chk("t6_pre_wb_ready", {31'b0, wb_ready}, 32'd1);
    idle(); reset = 1'b1; #1;
    chk("t6_op_valid", {31'b0, op_valid}, 32'd0);
    chk("t6_rd_write", {31'b0, rf_rd_write}, 32'd0);
    chk("t6_wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("t6_op_rs1", op_rs1_val, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_no_write_%0d", i), {31'b0, rf_rd_write}, 32'd0);
    end
    chk("t6_mem10", mem[10], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Initiator-side controller for the core's single-port-group register file, which has two combinational read ports and one synchronous write port.
- Sequences operand reads for decoded instructions and writeback commits onto that file. A read and a write are never issued in the same cycle, because the register file forces read data to 0 while its write is asserted.
- Buffers writebacks in a small FIFO, blocks RAW hazards against buffered writes, and drops writes to x0.

Parameters:
- WB_DEPTH, 4, writeback FIFO entries; power of 2, minimum 2.
- STARVE_MAX, 3, maximum consecutive read grants while the FIFO is non-empty before one write is forced.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- dec_valid  in  1  decoded instruction requests operands
- dec_ready  out  1  operands read this cycle (combinational grant)
- dec_rs1  in  5  source register 1 index
- dec_rs2  in  5  source register 2 index
- dec_use_rs1  in  1  rs1 is needed
- dec_use_rs2  in  1  rs2 is needed
- op_valid  out  1  captured operands are valid
- op_ready  in  1  execute stage accepts the operands
- op_rs1_val  out  32  captured rs1 value
- op_rs2_val  out  32  captured rs2 value
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted
- wb_rd  in  5  destination register index
- wb_data  in  32  writeback data
- rf_rs1_addr  out  32  to register file; rs1 index zero-extended
- rf_rs2_addr  out  32  to register file; rs2 index zero-extended
- rf_read_rs1  out  1  read enable, port 1
- rf_read_rs2  out  1  read enable, port 2
- rf_rs1  in  32  register file read data, port 1
- rf_rs2  in  32  register file read data, port 2
- rf_rd  out  32  write index, zero-extended from the FIFO head
- rf_rd_data  out  32  write data from the FIFO head
- rf_rd_write  out  1  write strobe; the register file commits at posedge clk

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO emptied; starve counter cleared.
  - op_valid=0, op_rs1_val=0, op_rs2_val=0.
  - All rf_* enables and strobes are 0 (combinational, because their grants are 0).
- Writeback acceptance:
  - wb_ready = (FIFO count < WB_DEPTH). No same-cycle pass-through when full.
  - Handshake wb_valid & wb_ready with wb_rd != 0: entry enqueued at the edge.
  - Handshake with wb_rd == 0: accepted, then discarded.
- Hazard:
  - hz = dec_use_rsN & dec_rsN != 0 & (dec_rsN matches any valid FIFO entry, or matches the wb_rd entry accepted this cycle), for either source.
- Read request:
  - rd_req = dec_valid & ~hz & (~op_valid | op_ready).
- Port arbitration, evaluated every cycle, at most one grant:
  - Write grant when FIFO non-empty and any of: ~rd_req; FIFO full; starve counter == STARVE_MAX.
  - Otherwise read grant = rd_req.
- On write grant:
  - rf_rd_write=1; rf_rd and rf_rd_data driven from the FIFO head.
  - Head popped at the edge; starve counter cleared.
  - rf_read_rs1=0 and rf_read_rs2=0.
- On read grant:
  - rf_read_rsN = dec_use_rsN; rf_rd_write=0; dec_ready=1.
  - op_rsN_val <= rf_rsN at the edge; unused operands capture 0 because the register file outputs 0 when the port is disabled.
  - op_valid <= 1.
  - Starve counter increments, saturating at STARVE_MAX, only if the FIFO is non-empty; cleared when the FIFO is empty.
- No grant, or write grant: dec_ready=0.
- Output register (two states, EMPTY/HOLD):
  - EMPTY to HOLD on a read grant.
  - HOLD to EMPTY on op_ready with no read grant.
  - HOLD stays HOLD on op_ready with a read grant (back-to-back reads, one per cycle).
  - HOLD without op_ready: op_* values held stable.
- Address outputs: rf_rs1_addr and rf_rs2_addr = {27'b0, dec_rsN} at all times. rf_rd and rf_rd_data = head entry, or 0 when the FIFO is empty.
- FIFO pointers: log2(WB_DEPTH)+1 bits, wrapping naturally. Enqueue and pop in the same cycle leaves the count unchanged.
- Ordering: writes commit in arrival order. A read never observes a value older than a buffered or same-cycle-accepted write to the same register.
- Latency:
  - Read: op_valid one cycle after the dec_valid cycle, when there is no hazard and no contention.
  - Write: committed at the earliest one edge after acceptance, the first cycle it wins the port.

Test Plan:
1. Reset, then wb x5=0xDEADBEEF with no reads. Required: rf_rd_write=1 with rf_rd=5 the cycle after acceptance, exactly once; FIFO empty afterwards.
2. wb x0=0x1234. Required: wb_ready=1, no rf_rd_write ever pulses, count stays 0.
3. FIFO holds x7, then dec rs1=7 use_rs1=1. Required: dec_ready=0 until x7 is written; read granted the next cycle; op_rs1_val=new x7 value; rf_read and rf_rd_write never high together (assert every cycle).
4. dec_valid held with rs1=1, rs2=2 (no hazard), op_ready=1, and a wb to x9 each cycle until full. Required: at most STARVE_MAX=3 consecutive dec_ready pulses while FIFO non-empty, then one write; wb_ready=0 at count 4; write forced when full.
5. Read with use_rs2=0 and x2 preloaded to 2. Required: op_rs2_val=0 and rf_read_rs2=0; with op_ready=0, op_* stable and dec_ready=0 on the next dec_valid.
6. Assert reset mid-operation with FIFO=3 entries and op_valid=1. Required: immediately op_valid=0, rf_rd_write=0, wb_ready=1; the old entries are never written after release.
